// File: rtl/ascon_pkg.sv
// Shared types and constants for the Ascon decryption datapath.
// Holds the state layout, IV, round-constant table and FSM encoding.
package ascon_pkg;

  typedef struct packed {
    logic [63:0] s4;
    logic [63:0] s3;
    logic [63:0] s2;
    logic [63:0] s1;
    logic [63:0] s0;
  } type_state;

  localparam logic [63:0] ASCON_IV = 64'h00001000808c0001;

  // Round i adds ((15 - i) << 4) | i to S2.
  localparam logic [7:0] ROUND_CONST [12] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  typedef enum logic [3:0] {
    IDLE, INIT, WAIT_AD, AD, WAIT_C1, C1, WAIT_C2, C2, DONE
  } fsm_state_t;

  function automatic logic [63:0] rotr64(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon permutation round: constant add, bitsliced S-box,
// then the per-word linear diffusion layer.
module ascon_round
  import ascon_pkg::*;
(
  input  type_state  state_in,
  input  logic [3:0] round_idx,
  output type_state  state_out
);

  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] t0, t1, t2, t3, t4;

  always_comb begin
    x0 = state_in.s0;
    x1 = state_in.s1;
    x2 = state_in.s2 ^ {56'h0, ROUND_CONST[round_idx]};
    x3 = state_in.s3;
    x4 = state_in.s4;

    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    state_out.s0 = x0 ^ rotr64(x0, 19) ^ rotr64(x0, 28);
    state_out.s1 = x1 ^ rotr64(x1, 61) ^ rotr64(x1, 39);
    state_out.s2 = x2 ^ rotr64(x2, 1)  ^ rotr64(x2, 6);
    state_out.s3 = x3 ^ rotr64(x3, 10) ^ rotr64(x3, 17);
    state_out.s4 = x4 ^ rotr64(x4, 7)  ^ rotr64(x4, 41);
  end

endmodule

// File: rtl/ascon_decrypt_top.sv
// Ascon decryptor: one permutation round per cycle, AD + two ciphertext blocks,
// plaintext released per block, tag checked at the end.
//
// state   | meaning
// IDLE    | waiting for start_i
// INIT    | p12 over key/nonce state, key folded in at the end
// WAIT_AD | waiting for associated data block
// AD      | p8 after absorbing AD, domain bit set at the end
// WAIT_C1 | waiting for ciphertext block 1
// C1      | p8 after block 1
// WAIT_C2 | waiting for ciphertext block 2 and received tag
// C2      | p12 finalisation, tag computed and compared
// DONE    | result held, start_i begins a new decryption
module ascon_decrypt_top
  import ascon_pkg::*;
(
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic         data_valid_i,
  input  logic [127:0] key_i,
  input  logic [127:0] nonce_i,
  input  logic [127:0] data_i,
  input  logic [127:0] tag_i,
  output logic         plain_valid_o,
  output logic [127:0] plain_o,
  output logic [127:0] tag_o,
  output logic         auth_ok_o,
  output logic         end_initialisation_o,
  output logic         end_associate_o,
  output logic         end_plain1_o,
  output logic         end_plain2_o,
  output logic         end_o
);

  fsm_state_t   state_q;
  type_state    s_q;
  type_state    s_rnd;
  logic [3:0]   rnd_q;
  logic [127:0] tag_rx_q;
  logic [63:0]  key_lo;
  logic [63:0]  key_hi;
  logic         last_rnd;
  logic [127:0] tag_calc;

  assign key_lo   = key_i[63:0];
  assign key_hi   = key_i[127:64];
  assign last_rnd = (rnd_q == 4'd11);
  assign tag_calc = {s_rnd.s4 ^ key_hi, s_rnd.s3 ^ key_lo};

  ascon_round u_round (
    .state_in  (s_q),
    .round_idx (rnd_q),
    .state_out (s_rnd)
  );

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q              <= IDLE;
      s_q                  <= '0;
      rnd_q                <= '0;
      tag_rx_q             <= '0;
      plain_valid_o        <= 1'b0;
      plain_o              <= '0;
      tag_o                <= '0;
      auth_ok_o            <= 1'b0;
      end_initialisation_o <= 1'b0;
      end_associate_o      <= 1'b0;
      end_plain1_o         <= 1'b0;
      end_plain2_o         <= 1'b0;
      end_o                <= 1'b0;
    end else begin
      plain_valid_o        <= 1'b0;
      end_initialisation_o <= 1'b0;
      end_associate_o      <= 1'b0;
      end_plain1_o         <= 1'b0;
      end_plain2_o         <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            s_q       <= '{s4: nonce_i[127:64], s3: nonce_i[63:0],
                           s2: key_hi, s1: key_lo, s0: ASCON_IV};
            rnd_q     <= 4'd0;
            end_o     <= 1'b0;
            auth_ok_o <= 1'b0;
            state_q   <= INIT;
          end
        end
        INIT: begin
          s_q <= s_rnd;
          if (last_rnd) begin
            s_q.s3               <= s_rnd.s3 ^ key_lo;
            s_q.s4               <= s_rnd.s4 ^ key_hi;
            end_initialisation_o <= 1'b1;
            state_q              <= WAIT_AD;
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        WAIT_AD: begin
          if (data_valid_i) begin
            s_q.s0  <= s_q.s0 ^ data_i[63:0];
            s_q.s1  <= s_q.s1 ^ data_i[127:64];
            rnd_q   <= 4'd4;
            state_q <= AD;
          end
        end
        AD: begin
          s_q <= s_rnd;
          if (last_rnd) begin
            s_q.s4          <= s_rnd.s4 ^ 64'h1;
            end_associate_o <= 1'b1;
            state_q         <= WAIT_C1;
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        WAIT_C1: begin
          if (data_valid_i) begin
            plain_o       <= data_i ^ {s_q.s1, s_q.s0};
            plain_valid_o <= 1'b1;
            s_q.s0        <= data_i[63:0];
            s_q.s1        <= data_i[127:64];
            rnd_q         <= 4'd4;
            state_q       <= C1;
          end
        end
        C1: begin
          s_q <= s_rnd;
          if (last_rnd) begin
            end_plain1_o <= 1'b1;
            state_q      <= WAIT_C2;
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        WAIT_C2: begin
          if (data_valid_i) begin
            plain_o       <= data_i ^ {s_q.s1, s_q.s0};
            plain_valid_o <= 1'b1;
            s_q.s0        <= data_i[63:0];
            s_q.s1        <= data_i[127:64];
            s_q.s2        <= s_q.s2 ^ key_lo;
            s_q.s3        <= s_q.s3 ^ key_hi;
            tag_rx_q      <= tag_i;
            end_plain2_o  <= 1'b1;
            rnd_q         <= 4'd0;
            state_q       <= C2;
          end
        end
        C2: begin
          s_q <= s_rnd;
          if (last_rnd) begin
            tag_o     <= tag_calc;
            // Whole-width reduce keeps the compare time independent of the data.
            auth_ok_o <= ~|(tag_calc ^ tag_rx_q);
            end_o     <= 1'b1;
            state_q   <= DONE;
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_decrypt_top.sv
// Scoreboard bench: a table-driven Ascon encryptor produces C1/C2/tag, the
// driver feeds them to the decryptor and a monitor checks plaintexts and tags.
module tb_ascon_decrypt_top;

  localparam logic [127:0] KEY   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] NONCE = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] AD_BLK = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1    = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] P2    = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [63:0]  IV    = 64'h00001000808c0001;
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  logic         clock_i = 1'b0;
  logic         resetb_i = 1'b0;
  logic         start_i = 1'b0;
  logic         data_valid_i = 1'b0;
  logic [127:0] key_i = KEY;
  logic [127:0] nonce_i = NONCE;
  logic [127:0] data_i = '0;
  logic [127:0] tag_i = '0;
  logic         plain_valid_o;
  logic [127:0] plain_o;
  logic [127:0] tag_o;
  logic         auth_ok_o;
  logic         end_initialisation_o;
  logic         end_associate_o;
  logic         end_plain1_o;
  logic         end_plain2_o;
  logic         end_o;

  ascon_decrypt_top dut (
    .clock_i              (clock_i),
    .resetb_i             (resetb_i),
    .start_i              (start_i),
    .data_valid_i         (data_valid_i),
    .key_i                (key_i),
    .nonce_i              (nonce_i),
    .data_i               (data_i),
    .tag_i                (tag_i),
    .plain_valid_o        (plain_valid_o),
    .plain_o              (plain_o),
    .tag_o                (tag_o),
    .auth_ok_o            (auth_ok_o),
    .end_initialisation_o (end_initialisation_o),
    .end_associate_o      (end_associate_o),
    .end_plain1_o         (end_plain1_o),
    .end_plain2_o         (end_plain2_o),
    .end_o                (end_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic [127:0] tag;
    logic         ok;
  } end_exp_t;

  int           n_tests = 0;
  int           n_fail = 0;
  int           cyc = 0;
  logic         end_prev = 1'b0;
  logic [127:0] q_plain [$];
  end_exp_t     q_end [$];

  always @(posedge clock_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic finish_now();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Reference round: S-box applied column by column from the 32-entry table.
  function automatic logic [319:0] tb_round(input logic [319:0] s, input int r);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  col;
    logic [4:0]  sb;
    for (int i = 0; i < 5; i++) x[i] = s[64*i +: 64];
    x[2] = x[2] ^ 64'((15 - r) * 16 + r);
    for (int b = 0; b < 64; b++) begin
      col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
      sb  = SBOX[col];
      for (int i = 0; i < 5; i++) y[i][b] = sb[4-i];
    end
    x[0] = y[0] ^ rotr(y[0], 19) ^ rotr(y[0], 28);
    x[1] = y[1] ^ rotr(y[1], 61) ^ rotr(y[1], 39);
    x[2] = y[2] ^ rotr(y[2], 1)  ^ rotr(y[2], 6);
    x[3] = y[3] ^ rotr(y[3], 10) ^ rotr(y[3], 17);
    x[4] = y[4] ^ rotr(y[4], 7)  ^ rotr(y[4], 41);
    return {x[4], x[3], x[2], x[1], x[0]};
  endfunction

  function automatic void model_encrypt(input logic [127:0] k, input logic [127:0] n,
                                        input logic [127:0] ad, input logic [127:0] p1,
                                        input logic [127:0] p2, output logic [127:0] c1,
                                        output logic [127:0] c2, output logic [127:0] tg);
    logic [319:0] s;
    s = {n[127:64], n[63:0], k[127:64], k[63:0], IV};
    for (int r = 0; r < 12; r++) s = tb_round(s, r);
    s[255:192] = s[255:192] ^ k[63:0];
    s[319:256] = s[319:256] ^ k[127:64];
    s[127:0] = s[127:0] ^ ad;
    for (int r = 4; r < 12; r++) s = tb_round(s, r);
    s[256] = ~s[256];
    s[127:0] = s[127:0] ^ p1;
    c1 = s[127:0];
    for (int r = 4; r < 12; r++) s = tb_round(s, r);
    s[127:0] = s[127:0] ^ p2;
    c2 = s[127:0];
    s[191:128] = s[191:128] ^ k[63:0];
    s[255:192] = s[255:192] ^ k[127:64];
    for (int r = 0; r < 12; r++) s = tb_round(s, r);
    tg = {s[319:256] ^ k[127:64], s[255:192] ^ k[63:0]};
  endfunction

  always @(negedge clock_i) begin
    if (!resetb_i) begin
      end_prev <= 1'b0;
    end else begin
      if (plain_valid_o) begin
        if (q_plain.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_plain: got %h expected no pulse", plain_o);
        end else begin
          check("plain_o", plain_o, q_plain.pop_front());
        end
      end
      if (end_o && !end_prev) begin
        if (q_end.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_end: got end_o=1 expected no end");
        end else begin
          end_exp_t e;
          e = q_end.pop_front();
          check("tag_o", tag_o, e.tag);
          check("auth_ok_o", 128'(auth_ok_o), 128'(e.ok));
        end
      end
      end_prev <= end_o;
    end
  end

  task automatic wait_sig(input int which, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clock_i);
      case (which)
        0:       hit = end_initialisation_o;
        1:       hit = end_associate_o;
        2:       hit = end_plain1_o;
        default: hit = end_o;
      endcase
    end
    if (!hit) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout_%s: got no pulse in 200 cycles expected pulse", name);
      finish_now();
    end
  endtask

  task automatic present(input logic [127:0] d, input logic stall);
    if (stall) begin
      bit quiet = 1'b1;
      data_valid_i = 1'b0;
      repeat (5) begin
        @(negedge clock_i);
        if (end_initialisation_o | end_associate_o | end_plain1_o |
            end_plain2_o | end_o | plain_valid_o) quiet = 1'b0;
      end
      check("stall_quiet", 128'(quiet), 128'(1));
    end
    data_i = d;
    data_valid_i = 1'b1;
    @(negedge clock_i);
    data_valid_i = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_flags"}, 128'({plain_valid_o, auth_ok_o, end_initialisation_o,
          end_associate_o, end_plain1_o, end_plain2_o, end_o}), 128'(0));
    check({name, "_plain"}, plain_o, 128'(0));
    check({name, "_tag"}, tag_o, 128'(0));
  endtask

  task automatic run(input logic tamper, input logic stall, input logic abort_c1,
                     input logic inject);
    logic [127:0] c1, c2, tg;
    int t0;
    model_encrypt(KEY, NONCE, AD_BLK, P1, P2, c1, c2, tg);
    @(negedge clock_i);
    start_i = 1'b1;
    t0 = cyc;
    if (inject) begin
      data_i = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
      data_valid_i = 1'b1;
    end
    @(negedge clock_i);
    start_i = 1'b0;
    if (inject) begin
      repeat (2) @(negedge clock_i);
      data_valid_i = 1'b0;
    end
    wait_sig(0, "end_init");
    present(AD_BLK, stall);
    if (inject) begin
      start_i = 1'b1;
      repeat (2) @(negedge clock_i);
      start_i = 1'b0;
    end
    wait_sig(1, "end_assoc");
    q_plain.push_back(P1);
    present(c1, stall);
    if (abort_c1) begin
      repeat (3) @(negedge clock_i);
      resetb_i = 1'b0;
      #1;
      check_all_zero("abort_rst");
      @(negedge clock_i);
      check_all_zero("abort_hold");
      resetb_i = 1'b1;
      return;
    end
    wait_sig(2, "end_plain1");
    q_plain.push_back(P2);
    q_end.push_back('{tag: tg, ok: !tamper});
    tag_i = tamper ? (tg ^ 128'h1) : tg;
    present(c2, stall);
    check("end_plain2_pulse", 128'(end_plain2_o), 128'(1));
    wait_sig(3, "end");
    if (!stall) check("latency", 128'(cyc - t0), 128'(44));
    repeat (2) @(negedge clock_i);
    check("done_hold", {tag_o[127:2], auth_ok_o, end_o}, {tg[127:2], !tamper, 1'b1});
  endtask

  initial begin
    #200000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: got no completion expected finish");
    finish_now();
  end

  initial begin
    repeat (3) @(negedge clock_i);
    check_all_zero("reset");
    resetb_i = 1'b1;
    run(1'b0, 1'b0, 1'b0, 1'b0);
    run(1'b1, 1'b0, 1'b0, 1'b0);
    run(1'b0, 1'b1, 1'b0, 1'b0);
    run(1'b0, 1'b0, 1'b1, 1'b0);
    run(1'b0, 1'b0, 1'b0, 1'b0);
    run(1'b0, 1'b0, 1'b0, 1'b1);
    run(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clock_i);
    check("queues_drained", 128'(q_plain.size() + q_end.size()), 128'(0));
    finish_now();
  end

endmodule
